// File: rtl/frame_pacer.sv
// Frame pacer: paces renderer frame requests off a prescaler tick and flags late acknowledges.
// Optional FRAME_PACER_OVERRUN_CNT_EN adds a saturating 8-bit overrun_count output.
module frame_pacer #(
  parameter int TICKS_PER_FRAME = 4,
  parameter int NUM_FRAMES      = 6572,
  parameter int FRAME_W         = 13
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  output logic               frame_req,
  input  logic               frame_ack,
  output logic [FRAME_W-1:0] frame_index,
  output logic               busy,
  output logic               done,
  output logic               overrun
`ifdef FRAME_PACER_OVERRUN_CNT_EN
  ,
  output logic [7:0]         overrun_count
`endif
);

  localparam int CNT_W = (TICKS_PER_FRAME > 2) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0]   LAST_TICK  = CNT_W'(TICKS_PER_FRAME - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PACE = 2'd1,
    S_REQ  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic [FRAME_W-1:0] r_frame_index;
  logic               r_frame_req;
  logic               r_pending;
  logic               r_done;
  logic               r_overrun;
`ifdef FRAME_PACER_OVERRUN_CNT_EN
  logic [7:0]         r_ovr_cnt;
`endif

  logic               w_elapse;
  logic               w_ack;
  logic [CNT_W-1:0]   w_tick_next;

  assign w_elapse    = tick && (r_tick_cnt == LAST_TICK);
  // An ack only counts while a request is actually on the wire (not during the one-cycle gap).
  assign w_ack       = frame_ack && r_frame_req;
  assign w_tick_next = w_elapse ? '0 : (r_tick_cnt + 1'b1);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tick_cnt    <= '0;
      r_frame_index <= '0;
      r_frame_req   <= 1'b0;
      r_pending     <= 1'b0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef FRAME_PACER_OVERRUN_CNT_EN
      r_ovr_cnt     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state     <= S_IDLE;
        r_frame_req <= 1'b0;
        r_pending   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state       <= S_REQ;
              r_frame_req   <= 1'b1;
              r_frame_index <= '0;
              r_tick_cnt    <= '0;
              r_pending     <= 1'b0;
              r_overrun     <= 1'b0;
`ifdef FRAME_PACER_OVERRUN_CNT_EN
              r_ovr_cnt     <= '0;
`endif
            end
          end
          S_PACE: begin
            if (tick) r_tick_cnt <= w_tick_next;
            if (w_elapse) begin
              r_state       <= S_REQ;
              r_frame_req   <= 1'b1;
              r_frame_index <= r_frame_index + 1'b1;
            end
          end
          S_REQ: begin
            if (tick) r_tick_cnt <= w_tick_next;
            if (w_elapse) begin
              r_overrun <= 1'b1;
`ifdef FRAME_PACER_OVERRUN_CNT_EN
              if (r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
`endif
            end
            if (w_ack) begin
              r_frame_req <= 1'b0;
              if (r_frame_index == LAST_FRAME) begin
                r_state   <= S_IDLE;
                r_done    <= 1'b1;
                r_pending <= 1'b0;
              end else if (r_pending || w_elapse) begin
                // Catch up on the missed period: next frame, re-request after a one-cycle gap.
                r_pending     <= 1'b0;
                r_frame_index <= r_frame_index + 1'b1;
              end else begin
                r_state <= S_PACE;
              end
            end else begin
              if (w_elapse) r_pending <= 1'b1;
              r_frame_req <= 1'b1;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_frame_req <= 1'b0;
          end
        endcase
      end
    end
  end

  assign frame_req   = r_frame_req;
  assign frame_index = r_frame_index;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign overrun     = r_overrun;
`ifdef FRAME_PACER_OVERRUN_CNT_EN
  assign overrun_count = r_ovr_cnt;
`endif

endmodule

// File: doc/frame_pacer.md
FRAME_PACER -- requirements
Module: frame_pacer

Interface
REQ-001 Parameter TICKS_PER_FRAME, default 4, SHALL set the prescaler ticks per frame period (legal range >= 2).
REQ-002 Parameter NUM_FRAMES, default 6572, SHALL set the total frames per playback (legal range >= 1).
REQ-003 Parameter FRAME_W, default 13, SHALL set the frame_index width (2^FRAME_W >= NUM_FRAMES).
REQ-004 clk_in  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 tick  input  1  single-cycle enable strobe from the power-of-2 prescaler rising strobe.
REQ-007 start  input  1  pulse; begins playback from frame 0.
REQ-008 stop  input  1  pulse; aborts playback.
REQ-009 frame_req  output  1  request to the renderer to fetch/draw frame_index.
REQ-010 frame_ack  input  1  renderer accepts the current request.
REQ-011 frame_index  output  FRAME_W  index of the requested/current frame.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse when the last frame is acknowledged.
REQ-014 overrun  output  1  sticky; a frame period elapsed while a request was outstanding.

Function
REQ-015 The FSM SHALL have states IDLE, PACE and REQ.
REQ-016 IDLE: start SHALL clear frame_index, tick_cnt, pending and overrun, then enter REQ; frame_req SHALL be high the cycle after start.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 REQ: frame_req SHALL stay high until frame_ack is sampled high; frame_req SHALL be registered, low in IDLE/PACE.
REQ-019 tick_cnt SHALL advance on every tick in PACE and REQ; on a tick with tick_cnt == TICKS_PER_FRAME-1 it SHALL wrap to 0 ("period elapse").
REQ-020 Period elapse in PACE SHALL enter REQ with frame_index + 1 already applied.
REQ-021 Period elapse in REQ (ack not yet seen, or ack in same cycle) SHALL set pending and overrun; pending SHALL hold at most one elapse.
REQ-022 frame_ack in REQ on the last frame (frame_index == NUM_FRAMES-1) SHALL pulse done and enter IDLE; frame_index SHALL hold its value.
REQ-023 Otherwise, frame_ack in REQ SHALL enter PACE, or, if pending is set, SHALL clear pending, increment frame_index and stay in REQ with frame_req deasserted for exactly one cycle.
REQ-024 frame_ack while frame_req is low SHALL be ignored.
REQ-025 stop SHALL take priority over start, tick and frame_ack and SHALL enter IDLE next cycle with frame_req low and done not pulsed; frame_index and overrun SHALL hold.
REQ-026 frame_index SHALL never exceed NUM_FRAMES-1.

Reset
REQ-027 rst SHALL asynchronously force state IDLE, frame_req 0, frame_index 0, tick_cnt 0, pending 0, busy 0, done 0, overrun 0.
REQ-028 rst asserted during REQ SHALL drop frame_req without waiting for frame_ack.

Configuration
REQ-029 With FRAME_PACER_OVERRUN_CNT_EN defined, an 8-bit output overrun_count SHALL count every period elapse during REQ, saturate at 255, clear on start and on rst.
REQ-030 Without FRAME_PACER_OVERRUN_CNT_EN, the overrun_count port and counter SHALL not exist; all other behaviour SHALL be identical.

Verification (TICKS_PER_FRAME=4, NUM_FRAMES=3)
REQ-031 start, ack 1 cycle after each req, tick every 2 cycles -> frame_req for indices 0,1,2 spaced 4 ticks apart, done pulse once after the 3rd ack, busy low after.
REQ-032 Ack withheld for 5 ticks on frame 0 -> overrun=1, on ack frame_index=1, frame_req low exactly 1 cycle, then high again; with macro, overrun_count=1.
REQ-033 Ack withheld for 9 ticks -> only one pending request (index goes 0->1, not 0->2); overrun_count=2 with macro.
REQ-034 stop asserted with start, tick and frame_ack in the same cycle during REQ -> IDLE next cycle, frame_req 0, done 0, frame_index unchanged.
REQ-035 rst pulsed mid-REQ (between clock edges) -> frame_req, busy, overrun drop immediately; a later start restarts at frame_index 0.
REQ-036 start pulsed while busy -> ignored, frame_index and tick_cnt unaffected.
